// File: rtl/sync_frame_deserializer_if.sv
// Parallel output channel of the frame deserializer: payload word with valid/ready.
// Master drives data_out/data_valid, slave returns data_ready.
// Transfer occurs on a rising edge where data_valid and data_ready are both high.
`timescale 1ns/1ps
interface sync_frame_deserializer_if #(
    parameter int PAYLOAD_BITS = 8
);
    logic [PAYLOAD_BITS-1:0] data_out;
    logic                    data_valid;
    logic                    data_ready;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/sync_frame_deserializer.sv
// Captures a fixed-length payload from rx after each sync pulse and presents it as a parallel word.
// Latency: data_valid rises on the edge that samples the last payload bit (no extra cycles).
// Backpressure: a completed frame that finds the output still full (and not accepted that edge) is dropped and counted.
`timescale 1ns/1ps
module sync_frame_deserializer #(
    parameter int PAYLOAD_BITS = 8,
    parameter bit MSB_FIRST    = 1'b1,
    parameter int CNT_W        = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     rx,
    input  logic                     detected,
    sync_frame_deserializer_if.master out_if,
    output logic                     busy,
    output logic [CNT_W-1:0]         frame_count,
    output logic [CNT_W-1:0]         drop_count
);

    // Counter never needs to hold PAYLOAD_BITS itself: it wraps to 0 on the last bit.
    localparam int                BC_W     = (PAYLOAD_BITS > 2) ? $clog2(PAYLOAD_BITS) : 1;
    localparam logic [BC_W-1:0]   LAST_BIT = BC_W'(PAYLOAD_BITS - 1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [BC_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]        drop_cnt_q, drop_cnt_d;

    logic start;
    logic sample;
    logic complete;
    logic load;
    logic drop;

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: sync pulse only honoured from IDLE, capture ends on the last bit
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (detected) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: capture strobes decoded from the current state
    always_comb begin
        start    = 1'b0;
        sample   = 1'b0;
        complete = 1'b0;
        busy     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start  = detected;
                sample = detected;
            end
            ST_CAPTURE: begin
                sample   = 1'b1;
                busy     = 1'b1;
                complete = (bit_cnt_q == LAST_BIT);
            end
            default: ;
        endcase
    end

    // Datapath next state: shift in rx, decide load vs drop on frame completion
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        load        = 1'b0;
        drop        = 1'b0;

        // After PAYLOAD_BITS shifts every stale bit has been pushed out, so no clear is needed
        if (sample) begin
            if (MSB_FIRST) begin
                shift_d = {shift_q[PAYLOAD_BITS-2:0], rx};
            end else begin
                shift_d = {rx, shift_q[PAYLOAD_BITS-1:1]};
            end
        end

        if (start) begin
            bit_cnt_d = BC_W'(1);
        end else if (complete) begin
            bit_cnt_d = '0;
        end else if (busy) begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
        end

        // Output slot is free if empty or being drained on this same edge
        if (complete) begin
            load = !valid_q || out_if.data_ready;
            drop = !load;
        end

        if (load) begin
            data_d  = shift_d;
            valid_d = 1'b1;
        end else if (valid_q && out_if.data_ready) begin
            valid_d = 1'b0;
        end

        if (load && !(&frame_cnt_q)) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
        if (drop && !(&drop_cnt_q)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_if.data_out   = data_q;
    assign out_if.data_valid = valid_q;
    assign frame_count       = frame_cnt_q;
    assign drop_count        = drop_cnt_q;

endmodule

// File: tb/tb_sync_frame_deserializer.sv
// Scoreboard bench: two instances share one stimulus stream (MSB-first/8-bit counters and LSB-first/2-bit counters).
// Expected words are queued when a frame is sent; monitors pop and compare on every output handshake.
// Directed checks cover reset, counters, busy width, backpressure, retrigger and mid-capture reset.
`timescale 1ns/1ps
module tb_sync_frame_deserializer;

    logic clk;
    logic rstn;
    logic rx;
    logic detected;
    logic data_ready;

    logic       busy_a, busy_b;
    logic [7:0] fcnt_a, dcnt_a;
    logic [1:0] fcnt_b, dcnt_b;

    int checks;
    int errors;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    int busy_run;
    int last_busy_run;

    sync_frame_deserializer_if #(.PAYLOAD_BITS(8)) if_a ();
    sync_frame_deserializer_if #(.PAYLOAD_BITS(8)) if_b ();

    assign if_a.data_ready = data_ready;
    assign if_b.data_ready = data_ready;

    sync_frame_deserializer #(.PAYLOAD_BITS(8), .MSB_FIRST(1'b1), .CNT_W(8)) dut_a (
        .clk         (clk),
        .rstn        (rstn),
        .rx          (rx),
        .detected    (detected),
        .out_if      (if_a),
        .busy        (busy_a),
        .frame_count (fcnt_a),
        .drop_count  (dcnt_a)
    );

    sync_frame_deserializer #(.PAYLOAD_BITS(8), .MSB_FIRST(1'b0), .CNT_W(2)) dut_b (
        .clk         (clk),
        .rstn        (rstn),
        .rx          (rx),
        .detected    (detected),
        .out_if      (if_b),
        .busy        (busy_b),
        .frame_count (fcnt_b),
        .drop_count  (dcnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor A: every handshake must deliver the next queued word
    always @(negedge clk) begin
        if (rstn && if_a.data_valid && data_ready) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_extra_word actual=%0h expected=none", if_a.data_out);
            end else begin
                chk("a_word", {24'h0, if_a.data_out}, {24'h0, exp_a.pop_front()});
            end
        end
    end

    // Monitor B: same, for the LSB-first instance
    always @(negedge clk) begin
        if (rstn && if_b.data_valid && data_ready) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_extra_word actual=%0h expected=none", if_b.data_out);
            end else begin
                chk("b_word", {24'h0, if_b.data_out}, {24'h0, exp_b.pop_front()});
            end
        end
    end

    // Length of the most recent busy pulse of instance A
    always @(negedge clk) begin
        if (busy_a) begin
            busy_run++;
        end else begin
            if (busy_run != 0) last_busy_run = busy_run;
            busy_run = 0;
        end
    end

    task automatic drive_bit(input logic b, input logic d);
        rx       = b;
        detected = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b0, 1'b0);
    endtask

    // Payload bit k is v[7-k]; retrig_at re-pulses detected mid-frame; rdy_last raises ready on the completing edge only
    task automatic send_frame(input logic [7:0] v, input bit pre, input int retrig_at,
                              input bit rdy_last, input bit expect_load);
        logic [3:0] sync;
        sync = 4'b0110;
        if (expect_load) begin
            exp_a.push_back(v);
            exp_b.push_back(rev8(v));
        end
        if (pre) begin
            for (int i = 3; i >= 0; i--) drive_bit(sync[i], 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            if (rdy_last && k == 7) data_ready = 1'b1;
            drive_bit(v[7-k], (k == 0) || (k == retrig_at));
            if (rdy_last && k == 7) data_ready = 1'b0;
        end
        rx       = 1'b0;
        detected = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data_a"},  {24'h0, if_a.data_out}, 32'h0);
        chk({tag, "_valid_a"}, {31'h0, if_a.data_valid}, 32'h0);
        chk({tag, "_busy_a"},  {31'h0, busy_a}, 32'h0);
        chk({tag, "_fcnt_a"},  {24'h0, fcnt_a}, 32'h0);
        chk({tag, "_dcnt_a"},  {24'h0, dcnt_a}, 32'h0);
        chk({tag, "_data_b"},  {24'h0, if_b.data_out}, 32'h0);
        chk({tag, "_valid_b"}, {31'h0, if_b.data_valid}, 32'h0);
        chk({tag, "_fcnt_b"},  {30'h0, fcnt_b}, 32'h0);
    endtask

    initial begin
        logic [7:0] sat_frames [5];
        sat_frames = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        checks        = 0;
        errors        = 0;
        busy_run      = 0;
        last_busy_run = 0;
        rstn          = 1'b0;
        rx            = 1'b0;
        detected      = 1'b0;
        data_ready    = 1'b0;

        // Reset state
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(2);

        // Single frame A7 with ready high: B sees the bit-reversed E5
        data_ready = 1'b1;
        send_frame(8'hA7, 1'b1, -1, 1'b0, 1'b1);
        chk("f1_valid_a", {31'h0, if_a.data_valid}, 32'h1);
        chk("f1_data_a",  {24'h0, if_a.data_out}, 32'hA7);
        chk("f1_data_b",  {24'h0, if_b.data_out}, 32'hE5);
        chk("f1_busy_done", {31'h0, busy_a}, 32'h0);
        chk("f1_fcnt_a",  {24'h0, fcnt_a}, 32'h1);
        chk("f1_fcnt_b",  {30'h0, fcnt_b}, 32'h1);
        idle(1);
        chk("f1_valid_one_cycle", {31'h0, if_a.data_valid}, 32'h0);
        chk("f1_busy_width", last_busy_run, 32'd7);

        // Backpressure: 3C held, FF dropped
        data_ready = 1'b0;
        send_frame(8'h3C, 1'b1, -1, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b1, -1, 1'b0, 1'b0);
        chk("bp_data_a",  {24'h0, if_a.data_out}, 32'h3C);
        chk("bp_valid_a", {31'h0, if_a.data_valid}, 32'h1);
        chk("bp_dcnt_a",  {24'h0, dcnt_a}, 32'h1);
        chk("bp_fcnt_a",  {24'h0, fcnt_a}, 32'h2);
        chk("bp_dcnt_b",  {30'h0, dcnt_b}, 32'h1);
        chk("bp_fcnt_b",  {30'h0, fcnt_b}, 32'h2);
        data_ready = 1'b1;
        idle(1);
        data_ready = 1'b0;
        chk("bp_drain_valid_a", {31'h0, if_a.data_valid}, 32'h0);

        // Simultaneous accept of 11 and load of 22
        send_frame(8'h11, 1'b1, -1, 1'b0, 1'b1);
        send_frame(8'h22, 1'b1, -1, 1'b1, 1'b1);
        chk("sim_data_a",  {24'h0, if_a.data_out}, 32'h22);
        chk("sim_valid_a", {31'h0, if_a.data_valid}, 32'h1);
        chk("sim_dcnt_a",  {24'h0, dcnt_a}, 32'h1);
        chk("sim_fcnt_a",  {24'h0, fcnt_a}, 32'h4);
        chk("sim_fcnt_b_sat", {30'h0, fcnt_b}, 32'h3);
        data_ready = 1'b1;
        idle(1);

        // Retrigger mid-frame and on the completing edge are ignored
        send_frame(8'h96, 1'b1, 4, 1'b0, 1'b1);
        chk("rt4_fcnt_a", {24'h0, fcnt_a}, 32'h5);
        chk("rt4_busy_a", {31'h0, busy_a}, 32'h0);
        idle(12);
        chk("rt4_quiet_fcnt_a", {24'h0, fcnt_a}, 32'h5);
        chk("rt4_quiet_valid_a", {31'h0, if_a.data_valid}, 32'h0);
        send_frame(8'h0F, 1'b1, 7, 1'b0, 1'b1);
        chk("rt7_busy_a", {31'h0, busy_a}, 32'h0);
        idle(10);
        chk("rt7_fcnt_a", {24'h0, fcnt_a}, 32'h6);
        chk("rt7_busy_b", {31'h0, busy_b}, 32'h0);

        // Back-to-back frames: second sync on the edge right after completion
        send_frame(8'h01, 1'b1, -1, 1'b0, 1'b1);
        send_frame(8'h80, 1'b0, -1, 1'b0, 1'b1);
        chk("b2b_data_a", {24'h0, if_a.data_out}, 32'h80);
        chk("b2b_fcnt_a", {24'h0, fcnt_a}, 32'h8);
        idle(2);

        // Reset in the middle of a capture
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        rx = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        idle(10);
        chk("midrst_after_valid_a", {31'h0, if_a.data_valid}, 32'h0);
        chk("midrst_after_fcnt_a",  {24'h0, fcnt_a}, 32'h0);
        chk("midrst_after_dcnt_a",  {24'h0, dcnt_a}, 32'h0);

        // Five frames after reset: B's 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            send_frame(sat_frames[i], 1'b1, -1, 1'b0, 1'b1);
        end
        idle(3);
        chk("sat_fcnt_a", {24'h0, fcnt_a}, 32'h5);
        chk("sat_fcnt_b", {30'h0, fcnt_b}, 32'h3);
        chk("sat_dcnt_b", {30'h0, dcnt_b}, 32'h0);

        idle(4);
        chk("a_queue_drained", exp_a.size(), 32'h0);
        chk("b_queue_drained", exp_b.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_frame_deserializer.md
Name: sync_frame_deserializer

Overview:
- Downstream consumer of sequence_detector. It takes the same serial `rx` bit stream plus the detector's one-cycle `detected` pulse, which marks the end of the "0110" sync word.
- After each sync pulse it shifts in a fixed-length payload from `rx` and presents it as a parallel word on a valid/ready output.
- Keeps saturating counts of delivered and dropped frames for debug.

Parameters:
- PAYLOAD_BITS, 8: payload length in bits, legal range 2..32.
- MSB_FIRST, 1: 1 means the first captured bit lands in data_out[PAYLOAD_BITS-1]; 0 means it lands in data_out[0].
- CNT_W, 8: width of frame_count and drop_count.

Ports:
- clk, in, 1: single clock; all logic on the rising edge.
- rstn, in, 1: reset, asynchronous and active-low.
- rx, in, 1: serial data bit, same net that feeds sequence_detector.
- detected, in, 1: one-cycle sync pulse from sequence_detector.
- data_out, out, PAYLOAD_BITS: captured payload word.
- data_valid, out, 1: data_out holds an undelivered frame.
- data_ready, in, 1: consumer accepts data_out on an edge where data_valid=1.
- busy, out, 1: capture in progress.
- frame_count, out, CNT_W: frames loaded into the output register; saturates at all-ones.
- drop_count, out, CNT_W: completed frames discarded because the output register was full; saturates at all-ones.

Behaviour:
- Reset (rstn=0, async): state=IDLE, bit counter=0, shift register=0, data_out=0, data_valid=0, busy=0, frame_count=0, drop_count=0. Asynchronous assert, synchronous-to-clk release.
- States: IDLE and CAPTURE.
- IDLE:
  - On an edge where detected=1: sample rx as payload bit 0, set bit counter=1, go to CAPTURE, busy=1 after that edge.
  - rx is otherwise ignored in IDLE.
- CAPTURE:
  - On each edge: sample rx as the next payload bit and increment the bit counter.
  - On the edge that samples bit PAYLOAD_BITS-1: the frame is complete; return to IDLE; busy=0 after that edge.
  - detected=1 while in CAPTURE, including on the completing edge, is ignored. There is no retrigger or restart, and the ignored pulse does not start a new frame.
- Bit order:
  - MSB_FIRST=1: bit k goes to data_out[PAYLOAD_BITS-1-k].
  - MSB_FIRST=0: bit k goes to data_out[k].
- Frame timing: sync pulse sampled at edge E0 carries b0; the last bit arrives at edge E(N-1), N=PAYLOAD_BITS.
- Output load, on the completing edge:
  - If data_valid=0, or data_valid=1 and data_ready=1 on that same edge: load data_out with the full frame, data_valid=1, frame_count+1 (saturating).
  - Otherwise: keep data_out/data_valid unchanged, drop the frame, drop_count+1 (saturating).
- Output latency: data_valid rises immediately after edge E(N-1), i.e. zero extra cycles after the last bit.
- Handshake:
  - data_out is stable while data_valid=1 and data_ready=0.
  - An edge with data_valid=1 and data_ready=1 and no simultaneous load clears data_valid.
  - Simultaneous accept and load leaves data_valid=1 with the new word.
  - data_ready while data_valid=0 has no effect.
- Back-to-back frames: a new detected pulse is honoured on any IDLE edge. The earliest is edge E(N), one cycle after completion, giving a continuous stream.
- Counter saturation: both counters hold at 2^CNT_W-1 and never wrap.
- Reset mid-capture: the partial frame is discarded and all state is cleared as in Reset; no frame or drop is counted.

Test Plan:
- Single frame (PAYLOAD_BITS=8, MSB_FIRST=1): after reset, send rx=0,1,1,0; pulse detected with payload 1,0,1,0,0,1,1,1 beginning at that edge; data_ready=1 -> data_out=8'hA7 and data_valid=1 for exactly one cycle after the 8th bit; frame_count=1; busy high for exactly 7 cycles.
- Bit order with MSB_FIRST=0: same stimulus -> data_out=8'hE5.
- Backpressure: data_ready=0; frame 8'h3C is followed by a sync and frame 8'hFF -> data_out stays 8'h3C, drop_count=1, frame_count=1; raising data_ready for one edge clears data_valid.
- Simultaneous accept and load: data_valid=1 holding 8'h11, and data_ready=1 exactly on the completing edge of frame 8'h22 -> data_out=8'h22, data_valid stays 1, drop_count=0, frame_count=2.
- Retrigger ignored: a detected pulse at bit 4 of a capture -> the frame completes on the original 8-bit schedule with the original bits, no new frame starts, frame_count increments by exactly 1.
- Reset mid-capture and saturation:
  - rstn low at bit 3 -> all outputs 0, no frame delivered.
  - With CNT_W=2, deliver 5 frames -> frame_count=3.
